approx_mul_seq_ctrl: RTL and testbench
======================================

// Module: approx_mul_seq_ctrl
// PURPOSE
//  Sequential radix-2 shift-add multiplier controller that drives one row adder built from 1-bit
//  approximate adder cells (sum=b, cout=a) in the low APPROX_BITS lanes and exact full adders above.
//  Accepts an operand pair over a valid/ready request channel and iterates one multiplier bit per
//  cycle. Returns the 2*WIDTH-bit product over a valid/ready response channel.
//  Sits between the CPU coprocessor interface and the approximate datapath.
//  A per-request mode bit selects approximate or exact low lanes.
// PARAMETERS
//  WIDTH        32  operand width in bits; must be >= 2
//  APPROX_BITS  8   number of low adder lanes using approximate cells; must be 0..WIDTH; 0 = fully exact
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  req_valid    in   1        request operands valid
//  req_ready    out  1        controller can accept a request (high only in IDLE)
//  req_a        in   WIDTH    multiplicand, unsigned
//  req_b        in   WIDTH    multiplier, unsigned
//  req_approx   in   1        1 = approximate low lanes; 0 = exact addition in all lanes
//  resp_valid   out  1        product valid (high only in DONE)
//  resp_ready   in   1        consumer accepts product
//  resp_prod    out  2*WIDTH  product {hi,lo}
//  busy         out  1        high in RUN or DONE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE, cnt=0, hi=0, lo=0, carry=0, mode=0.
//    Outputs after reset: req_ready=1, resp_valid=0, busy=0, resp_prod=0.
//    rst has priority over every other event, including reset mid-RUN or mid-DONE; the
//    in-flight operation is dropped and no response is produced.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN on req_valid&&req_ready. On that edge: hi=0, lo=req_b, mcand=req_a,
//      mode=req_approx, cnt=0.
//    RUN, each cycle:
//      if lo[0]: {c,s} = row_add(hi, mcand, mode); else {c,s} = {1'b0, hi}.
//      Then {hi,lo} = {c, s, lo} >> 1 (c drops into hi[WIDTH-1]).
//      cnt++; when cnt==WIDTH-1 on this edge, go to DONE.
//    DONE: resp_valid=1, resp_prod={hi,lo} held stable. DONE -> IDLE on resp_valid&&resp_ready.
//  - Latency: accept edge E0; RUN iterations occupy edges E1..E_WIDTH; resp_valid is high in the
//    cycle after E_WIDTH.
//    Throughput: one op per WIDTH+2 cycles minimum (one IDLE bubble after each response).
//  - row_add(x, y, m), with K = APPROX_BITS:
//    m=1: s[K-1:0] = y[K-1:0]; carry into lane K = x[K-1] (0 when K=0);
//         {c, s[WIDTH-1:K]} = x[WIDTH-1:K] + y[WIDTH-1:K] + cin.
//    m=0: {c,s} = x + y, exact.
//    The cin input of the approximate cells is unused by definition.
//  - Boundaries:
//    req_valid while busy: ignored (req_ready=0), no side effect.
//    resp_ready held low: stay in DONE indefinitely with resp_prod unchanged.
//    req_b=0 or req_a=0: still takes the full WIDTH iterations; product is 0.
//    Operands 2^WIDTH-1: the carry bit prevents overflow loss; the exact product fits in 2*WIDTH bits.
//    K=WIDTH: the upper exact slice is empty; c = x[WIDTH-1].
//  - Arithmetic is unsigned throughout.
//    cnt width = $clog2(WIDTH), and cnt stops at WIDTH-1 with no wrap.
// STRUCTURE
//  - Shared package pico_mul_pkg:
//    FSM state encoding localparams ST_IDLE, ST_RUN, ST_DONE.
//    Default WIDTH and APPROX_BITS constants.
//  - One sub-module, approx_row_adder #(WIDTH, APPROX_BITS): purely combinational.
//    Instantiates APPROX_BITS x1_approx_add cells and an exact adder for the upper lanes,
//    with a mode mux.
//  - This module holds the FSM, counter, hi/lo/mcand/mode registers and the handshakes.
// TESTING (WIDTH=8, APPROX_BITS=2 unless noted)
//  1. Exact mode: a=3, b=3, approx=0 -> resp_prod=9; resp_valid rises exactly 8 cycles after the
//     accept edge.
//  2. Approx mode: a=3, b=3, approx=1 -> resp_prod=7. Check against a reference model of row_add.
//  3. Exact mode: a=255, b=255 -> resp_prod=16'hFE01. Random sweep with APPROX_BITS=0 -> always a*b.
//  4. Backpressure: resp_ready=0 for 20 cycles -> resp_valid stays 1, resp_prod stable.
//     Meanwhile req_valid=1 with new operands -> not accepted (req_ready=0).
//  5. Reset mid-RUN at iteration 4 -> the next cycle shows req_ready=1, resp_valid=0, busy=0.
//     A following request 5*6 in exact mode -> 30.
//  6. Back-to-back: req_valid held high, resp_ready=1 -> a new request is accepted on the edge after
//     each response handshake; products are correct in order.

Source files
------------

// File: rtl/pico_mul_pkg.sv
// pico_mul_pkg: shared FSM state encoding and default sizing for the approximate multiplier
package pico_mul_pkg;
   localparam int DEFAULT_WIDTH       = 32;
   localparam int DEFAULT_APPROX_BITS = 8;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/approx_mul_seq_ctrl_row_adder.sv
// approx_row_adder: one multiplier row adder, approximate low lanes (sum=b, cout=a) and exact upper lanes
//   x, y  in  WIDTH  addends (partial product high half, multiplicand)
//   mode  in  1      1 = approximate low APPROX_BITS lanes, 0 = exact everywhere
//   s     out WIDTH  sum
//   c     out 1      carry out of the top lane
module x1_approx_add (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic cout
);
   assign sum  = b;
   assign cout = a;
endmodule

module approx_row_adder
   import pico_mul_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int APPROX_BITS = DEFAULT_APPROX_BITS
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic             mode,
   output logic [WIDTH-1:0] s,
   output logic             c
);
   localparam int HW = WIDTH - APPROX_BITS;
   logic [WIDTH:0] exact_sum;
   logic [WIDTH:0] approx_sum;
   assign exact_sum = {1'b0, x} + {1'b0, y};
   if (APPROX_BITS == 0) begin : g_exact_only
      assign approx_sum = exact_sum;
   end else begin : g_approx
      logic [APPROX_BITS-1:0] lo_sum;
      logic [APPROX_BITS-1:0] lo_cout;
      for (genvar i = 0; i < APPROX_BITS; i++) begin : g_cell
         x1_approx_add u_cell (.a(x[i]), .b(y[i]), .sum(lo_sum[i]), .cout(lo_cout[i]));
      end
      if (HW == 0) begin : g_no_upper
         assign approx_sum = {lo_cout[APPROX_BITS-1], lo_sum};
      end else begin : g_upper
         // only the top approximate cell's carry reaches the exact slice
         logic [HW:0] hi_sum;
         assign hi_sum = {1'b0, x[WIDTH-1:APPROX_BITS]} + {1'b0, y[WIDTH-1:APPROX_BITS]}
                       + {{HW{1'b0}}, lo_cout[APPROX_BITS-1]};
         assign approx_sum = {hi_sum, lo_sum};
      end
   end
   assign {c, s} = mode ? approx_sum : exact_sum;
endmodule

// File: rtl/approx_mul_seq_ctrl.sv
// approx_mul_seq_ctrl: sequential radix-2 shift-add multiplier controller over an approximate row adder
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake; req_ready high only in IDLE
//   req_a, req_b, req_approx multiplicand, multiplier, approximate-low-lanes select
//   resp_valid/resp_ready    response handshake; resp_valid high only in DONE
//   resp_prod                2*WIDTH-bit product {hi,lo}
//   busy                     high in RUN or DONE
module approx_mul_seq_ctrl
   import pico_mul_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int APPROX_BITS = DEFAULT_APPROX_BITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic               req_approx,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [2*WIDTH-1:0] resp_prod,
   output logic               busy
);
   localparam int CW = $clog2(WIDTH);
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] row_s;
   logic             row_c;
   logic             last;
   approx_row_adder #(.WIDTH(WIDTH), .APPROX_BITS(APPROX_BITS)) u_row (
      .x(hi_q), .y(mcand_q), .mode(mode_q), .s(row_s), .c(row_c)
   );
   assign last       = cnt_q == CW'(WIDTH - 1);
   assign req_ready  = state_q == ST_IDLE;
   assign resp_valid = state_q == ST_DONE;
   assign busy       = state_q != ST_IDLE;
   assign resp_prod  = {hi_q, lo_q};
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mcand_d = mcand_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: if (req_valid) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = req_b;
            mcand_d = req_a;
            mode_d  = req_approx;
         end
         ST_RUN: begin
            // carry out of the row lands in hi[WIDTH-1] after the shift
            {hi_d, lo_d} = {lo_q[0] ? {row_c, row_s} : {1'b0, hi_q}, lo_q[WIDTH-1:1]};
            cnt_d        = last ? cnt_q : cnt_q + CW'(1);
            state_d      = last ? ST_DONE : ST_RUN;
         end
         ST_DONE: state_d = resp_ready ? ST_IDLE : ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         mcand_q <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mcand_q <= mcand_d;
         mode_q  <= mode_d;
      end
   end
endmodule

// File: tb/tb_approx_mul_seq_ctrl.sv
// tb_approx_mul_seq_ctrl: randomized and directed checks of the multiplier against a behavioural model
module tb_approx_mul_seq_ctrl;
   localparam int W = 8;
   localparam int K = 2;
   logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_approx = 1'b0, resp_ready = 1'b1;
   logic [W-1:0] req_a = '0, req_b = '0;
   logic req_ready, resp_valid, busy, x_req_ready, x_resp_valid, x_busy;
   logic [2*W-1:0] resp_prod, x_resp_prod;
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;

   approx_mul_seq_ctrl #(.WIDTH(W), .APPROX_BITS(K)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_prod(resp_prod), .busy(busy)
   );
   approx_mul_seq_ctrl #(.WIDTH(W), .APPROX_BITS(0)) u_exact (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(x_req_ready),
      .req_a(req_a), .req_b(req_b), .req_approx(req_approx),
      .resp_valid(x_resp_valid), .resp_ready(resp_ready), .resp_prod(x_resp_prod), .busy(x_busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // row addition from the arithmetic definition: low k bits copy y, upper slice adds with cin = x[k-1]
   function automatic logic [W:0] row_ref(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input int k);
      int unsigned up, cin, mask, r;
      if (!m) return {1'b0, x} + {1'b0, y};
      mask = (32'd1 << k) - 1;
      cin  = (k == 0) ? 0 : ((32'(x) >> (k - 1)) & 1);
      up   = (32'(x) >> k) + (32'(y) >> k) + cin;
      r    = (up << k) | (32'(y) & mask);
      return r[W:0];
   endfunction

   function automatic logic [2*W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input int k);
      logic [W:0] cs;
      logic [2*W:0] t;
      logic [2*W-1:0] acc;
      acc = {{W{1'b0}}, b};
      for (int i = 0; i < W; i++) begin
         cs  = acc[0] ? row_ref(acc[2*W-1:W], a, m, k) : {1'b0, acc[2*W-1:W]};
         t   = {cs, acc[W-1:0]} >> 1;
         acc = t[2*W-1:0];
      end
      return acc;
   endfunction

   // cycle-level model: idle / counting down W iterations / holding result
   logic m_busy = 1'b0, m_zero = 1'b1;
   int m_left = 0;
   logic [2*W-1:0] m_prod = '0, m_exact = '0;
   always @(posedge clk) begin
      if (rst) begin
         m_busy = 1'b0;
         m_left = 0;
         m_zero = 1'b1;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  = 1'b1;
            m_left  = W;
            m_zero  = 1'b0;
            m_prod  = mul_ref(req_a, req_b, req_approx, K);
            m_exact = {{W{1'b0}}, req_a} * {{W{1'b0}}, req_b};
         end
      end else if (m_left > 0) m_left--;
      else if (resp_ready) m_busy = 1'b0;
   end

   always @(negedge clk) begin
      check("req_ready", req_ready, !m_busy);
      check("busy", busy, m_busy);
      check("resp_valid", resp_valid, m_busy && m_left == 0);
      check("x_resp_valid", x_resp_valid, m_busy && m_left == 0);
      check("x_busy", x_busy, m_busy);
      check("x_req_ready", x_req_ready, !m_busy);
      if (m_busy && m_left == 0) begin
         check("prod", resp_prod, m_prod);
         check("exact_prod", x_resp_prod, m_exact);
      end
      if (m_zero) begin
         check("reset_prod", resp_prod, 0);
         check("x_reset_prod", x_resp_prod, 0);
      end
   end

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ap,
                        output logic [2*W-1:0] p, output int lat);
      int n = 0;
      req_a = a; req_b = b; req_approx = ap; req_valid = 1'b1;
      while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      check("op_done_in_time", resp_valid, 1);
      p = resp_prod;
   endtask

   logic [2*W-1:0] p, p0;
   int lat, hs;
   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_prod", resp_prod, 0);
      check("pin_exact_3x3", mul_ref(8'd3, 8'd3, 1'b0, K), 9);
      check("pin_approx_3x3", mul_ref(8'd3, 8'd3, 1'b1, K), 7);
      check("pin_exact_max", mul_ref(8'hFF, 8'hFF, 1'b0, K), 16'hFE01);
      check("pin_k0_approx", mul_ref(8'd77, 8'd201, 1'b1, 0), 77 * 201);
      do_op(8'd3, 8'd3, 1'b0, p, lat);
      check("t1_prod", p, 9);
      check("t1_latency", lat, 8);
      do_op(8'd3, 8'd3, 1'b1, p, lat);
      check("t2_prod", p, 7);
      do_op(8'hFF, 8'hFF, 1'b0, p, lat);
      check("t3_prod", p, 16'hFE01);
      do_op(8'd0, 8'hA5, 1'b1, p, lat);
      check("zero_a_prod", p, 0);
      check("zero_a_latency", lat, 8);
      // backpressure with a competing request that must be ignored
      resp_ready = 1'b0;
      do_op(8'd200, 8'd100, 1'b1, p0, lat);
      req_valid = 1'b1; req_a = 8'd17; req_b = 8'd19;
      repeat (20) begin @(posedge clk); #1; end
      check("t4_hold_valid", resp_valid, 1);
      check("t4_hold_prod", resp_prod, p0);
      check("t4_no_accept", req_ready, 0);
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      check("t4_released", resp_valid, 0);
      // reset on the fourth iteration edge
      req_a = 8'd9; req_b = 8'd13; req_approx = 1'b0; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      check("t5_req_ready", req_ready, 1);
      check("t5_resp_valid", resp_valid, 0);
      check("t5_busy", busy, 0);
      do_op(8'd5, 8'd6, 1'b0, p, lat);
      check("t5_prod", p, 30);
      // back-to-back with request always pending
      @(posedge clk); #1;
      hs = 0; req_valid = 1'b1; resp_ready = 1'b1;
      repeat (400) begin
         req_a = W'($urandom); req_b = W'($urandom); req_approx = 1'($urandom);
         @(posedge clk); #1;
         if (resp_valid) hs++;
      end
      check("t6_throughput", hs >= 39, 1);
      // fully random traffic including occasional resets and corner operands
      repeat (3000) begin
         req_valid  = 1'($urandom);
         resp_ready = ($urandom % 4) != 0;
         req_approx = 1'($urandom);
         req_a      = ($urandom % 5 == 0) ? 8'hFF : W'($urandom);
         req_b      = ($urandom % 7 == 0) ? 8'h00 : ($urandom % 5 == 0) ? 8'hFF : W'($urandom);
         rst        = ($urandom % 250) == 0;
         @(posedge clk); #1;
      end
      rst = 1'b0; req_valid = 1'b0;
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
